// File: rtl/mem_access_stage.sv
// Memory-access stage: runs a req/ack data-memory transaction for lw/sw/lbu/sb and stalls control.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without MM_Ack.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_Start,
  input  logic        MEM_WrEn,
  input  logic        ByteOp,
  input  logic [31:0] ALU_MEM_Addr,
  input  logic [31:0] MEM_DataIn,
  output logic        MM_Req,
  output logic        MM_WE,
  output logic [31:0] MM_Addr,
  output logic [31:0] MM_WrData,
  output logic [3:0]  MM_ByteEn,
  input  logic [31:0] MM_RdData,
  input  logic        MM_Ack,
  output logic [31:0] MEM_DataOut,
  output logic        MEM_busy,
  output logic        MEM_done,
  output logic        MEM_err
);

  typedef enum logic [1:0] {StIdle, StCheck, StAccess, StDone} state_e;

  state_e      r_state;
  logic        r_we;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_req;
  logic        r_mm_we;
  logic [31:0] r_mm_addr;
  logic [31:0] r_mm_wdata;
  logic [3:0]  r_mm_be;
  logic [31:0] r_dout;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
`ifdef MEM_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
`endif

  logic [1:0]  w_lane;
  logic        w_misaligned;
  logic [31:0] w_word_addr;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wr_data;
  logic [7:0]  w_rd_byte;
  logic [31:0] w_load_data;

  assign w_lane       = r_addr[1:0];
  assign w_misaligned = !r_byte && (w_lane != 2'b00);
  assign w_word_addr  = (r_addr - MEM_BASE) & ~32'h3;
  assign w_byte_en    = r_byte ? (4'b0001 << w_lane) : 4'b1111;
  assign w_wr_data    = r_byte ? {4{r_data[7:0]}} : r_data;

  always_comb begin
    w_rd_byte = MM_RdData[7:0];
    unique case (w_lane)
      2'd0: w_rd_byte = MM_RdData[7:0];
      2'd1: w_rd_byte = MM_RdData[15:8];
      2'd2: w_rd_byte = MM_RdData[23:16];
      2'd3: w_rd_byte = MM_RdData[31:24];
      default: w_rd_byte = MM_RdData[7:0];
    endcase
  end

  assign w_load_data = r_byte ? {24'b0, w_rd_byte} : MM_RdData;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
      r_req      <= 1'b0;
      r_mm_we    <= 1'b0;
      r_mm_addr  <= 32'h0;
      r_mm_wdata <= 32'h0;
      r_mm_be    <= 4'h0;
      r_dout     <= 32'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_tmo_cnt  <= 32'h0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (MEM_Start) begin
            r_we    <= MEM_WrEn;
            r_byte  <= ByteOp;
            r_addr  <= ALU_MEM_Addr;
            r_data  <= MEM_DataIn;
            r_busy  <= 1'b1;
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_misaligned) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            // Bus outputs are captured once here so they stay stable for the whole access.
            r_req      <= 1'b1;
            r_mm_we    <= r_we;
            r_mm_addr  <= w_word_addr;
            r_mm_wdata <= w_wr_data;
            r_mm_be    <= w_byte_en;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt  <= 32'h0;
`endif
            r_state    <= StAccess;
          end
        end
        StAccess: begin
          if (MM_Ack) begin
            if (!r_we) r_dout <= w_load_data;
            r_req   <= 1'b0;
            r_mm_we <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_tmo_cnt == TIMEOUT_CYC - 1) begin
            r_req   <= 1'b0;
            r_mm_we <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
          end
`endif
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign MM_Req      = r_req;
  assign MM_WE       = r_mm_we;
  assign MM_Addr     = r_mm_addr;
  assign MM_WrData   = r_mm_wdata;
  assign MM_ByteEn   = r_mm_be;
  assign MEM_DataOut = r_dout;
  assign MEM_busy    = r_busy;
  assign MEM_done    = r_done;
  assign MEM_err     = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: word/byte ops, misalignment, wait states, reset, timeout.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_Start;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic        MM_Req;
  logic        MM_WE;
  logic [31:0] MM_Addr;
  logic [31:0] MM_WrData;
  logic [3:0]  MM_ByteEn;
  logic [31:0] MM_RdData;
  logic        MM_Ack;
  logic [31:0] MEM_DataOut;
  logic        MEM_busy;
  logic        MEM_done;
  logic        MEM_err;

  int n_vec = 0;
  int n_err = 0;

  mem_access_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .MEM_Start    (MEM_Start),
    .MEM_WrEn     (MEM_WrEn),
    .ByteOp       (ByteOp),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MM_Req       (MM_Req),
    .MM_WE        (MM_WE),
    .MM_Addr      (MM_Addr),
    .MM_WrData    (MM_WrData),
    .MM_ByteEn    (MM_ByteEn),
    .MM_RdData    (MM_RdData),
    .MM_Ack       (MM_Ack),
    .MEM_DataOut  (MEM_DataOut),
    .MEM_busy     (MEM_busy),
    .MEM_done     (MEM_done),
    .MEM_err      (MEM_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Pulse MEM_Start for one cycle; returns in the CHECK cycle.
  task automatic start(input logic we, input logic bop, input logic [31:0] addr,
                       input logic [31:0] data);
    MEM_WrEn     = we;
    ByteOp       = bop;
    ALU_MEM_Addr = addr;
    MEM_DataIn   = data;
    MEM_Start    = 1'b1;
    step();
    MEM_Start    = 1'b0;
  endtask

  // Full single-cycle-ack transaction with bus checks in ACCESS and done check at +3.
  task automatic xact(input string tag, input logic we, input logic bop, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] rd, input logic [31:0] exp_addr,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd);
    start(we, bop, addr, data);
    check({tag, " busy@chk"}, {31'b0, MEM_busy}, 32'd1);
    step();
    check({tag, " req"}, {31'b0, MM_Req}, 32'd1);
    check({tag, " we"}, {31'b0, MM_WE}, {31'b0, we});
    check({tag, " addr"}, MM_Addr, exp_addr);
    check({tag, " be"}, {28'b0, MM_ByteEn}, {28'b0, exp_be});
    if (we) check({tag, " wdata"}, MM_WrData, exp_wd);
    MM_RdData = rd;
    MM_Ack    = 1'b1;
    step();
    MM_Ack    = 1'b0;
    check({tag, " done"}, {31'b0, MEM_done}, 32'd1);
    check({tag, " err"}, {31'b0, MEM_err}, 32'd0);
    check({tag, " busy@done"}, {31'b0, MEM_busy}, 32'd0);
    check({tag, " req@done"}, {31'b0, MM_Req}, 32'd0);
    step();
    check({tag, " done clr"}, {31'b0, MEM_done}, 32'd0);
  endtask

  initial begin
    int acc;
    logic seen_done;
    Reset = 1'b0; MEM_Start = 1'b0; MEM_WrEn = 1'b0; ByteOp = 1'b0;
    ALU_MEM_Addr = 32'h0; MEM_DataIn = 32'h0; MM_RdData = 32'h0; MM_Ack = 1'b0;
    step(); step();
    check("rst req", {31'b0, MM_Req}, 32'd0);
    check("rst busy", {31'b0, MEM_busy}, 32'd0);
    check("rst done", {31'b0, MEM_done}, 32'd0);
    check("rst dout", MEM_DataOut, 32'h0);
    check("rst be", {28'b0, MM_ByteEn}, 32'h0);
    check("rst addr", MM_Addr, 32'h0);
    Reset = 1'b1;
    step();

    xact("sw", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h10, 4'b1111, 32'hDEADBEEF);
    xact("lw", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h10, 4'b1111, 32'h0);
    check("lw dout", MEM_DataOut, 32'hDEADBEEF);
    xact("sb", 1'b1, 1'b1, 32'h13, 32'h000000A5, 32'h0, 32'h10, 4'b1000, 32'hA5A5A5A5);
    check("sb dout kept", MEM_DataOut, 32'hDEADBEEF);
    xact("lbu", 1'b0, 1'b1, 32'h12, 32'h0, 32'h11223344, 32'h10, 4'b0100, 32'h0);
    check("lbu dout", MEM_DataOut, 32'h00000022);

    // Misaligned word load: no bus cycle, stray ack ignored, error at +2.
    start(1'b0, 1'b0, 32'h06, 32'h0);
    check("mis req@chk", {31'b0, MM_Req}, 32'd0);
    MM_Ack = 1'b1; MM_RdData = 32'hFFFFFFFF;
    step();
    MM_Ack = 1'b0;
    check("mis done", {31'b0, MEM_done}, 32'd1);
    check("mis err", {31'b0, MEM_err}, 32'd1);
    check("mis req", {31'b0, MM_Req}, 32'd0);
    check("mis dout", MEM_DataOut, 32'h00000022);
    step();
    check("mis err clr", {31'b0, MEM_err}, 32'd0);

    // Five wait states with a stray MEM_Start mid-access.
    start(1'b1, 1'b0, 32'h20, 32'h12345678);
    step();
    for (int i = 0; i < 5; i++) begin
      check("ws req", {31'b0, MM_Req}, 32'd1);
      check("ws addr", MM_Addr, 32'h20);
      check("ws wdata", MM_WrData, 32'h12345678);
      check("ws busy", {31'b0, MEM_busy}, 32'd1);
      if (i == 2) begin
        ALU_MEM_Addr = 32'h44; MEM_DataIn = 32'h0; MEM_Start = 1'b1;
      end
      step();
      MEM_Start = 1'b0;
    end
    MM_Ack = 1'b1;
    step();
    MM_Ack = 1'b0;
    check("ws done", {31'b0, MEM_done}, 32'd1);
    step();
    check("ws no queue busy", {31'b0, MEM_busy}, 32'd0);
    step();
    check("ws no queue req", {31'b0, MM_Req}, 32'd0);

    // Asynchronous reset during ACCESS.
    start(1'b0, 1'b0, 32'h30, 32'h0);
    step();
    check("rma req", {31'b0, MM_Req}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("rma req drop", {31'b0, MM_Req}, 32'd0);
    check("rma busy drop", {31'b0, MEM_busy}, 32'd0);
    step();
    Reset = 1'b1;
    step();
    xact("lw2", 1'b0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 32'h30, 4'b1111, 32'h0);
    check("lw2 dout", MEM_DataOut, 32'hCAFEF00D);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 16 ACCESS cycles.
    start(1'b0, 1'b0, 32'h40, 32'h0);
    step();
    acc = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (MEM_done) begin
        seen_done = 1'b1;
        check("tmo err", {31'b0, MEM_err}, 32'd1);
      end else begin
        if (MM_Req) acc++;
        step();
      end
    end
    check("tmo seen done", {31'b0, seen_done}, 32'd1);
    check("tmo cycles", acc, 32'd16);
    check("tmo dout", MEM_DataOut, 32'hCAFEF00D);
    step();
    // Ack on the 16th ACCESS cycle wins over expiry.
    start(1'b0, 1'b0, 32'h44, 32'h0);
    step();
    for (int i = 1; i < 16; i++) begin
      check("tmo16 req", {31'b0, MM_Req}, 32'd1);
      step();
    end
    check("tmo16 req last", {31'b0, MM_Req}, 32'd1);
    MM_Ack = 1'b1; MM_RdData = 32'h0BADF00D;
    step();
    MM_Ack = 1'b0;
    check("tmo16 done", {31'b0, MEM_done}, 32'd1);
    check("tmo16 err", {31'b0, MEM_err}, 32'd0);
    check("tmo16 dout", MEM_DataOut, 32'h0BADF00D);
    step();
`else
    // No timeout: access waits indefinitely for ack.
    start(1'b0, 1'b0, 32'h40, 32'h0);
    step();
    acc = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MEM_done) seen_done = 1'b1;
      if (MM_Req) acc++;
      step();
    end
    check("wait no done", {31'b0, seen_done}, 32'd0);
    check("wait req cycles", acc, 32'd20);
    MM_Ack = 1'b1; MM_RdData = 32'h55AA55AA;
    step();
    MM_Ack = 1'b0;
    check("wait done", {31'b0, MEM_done}, 32'd1);
    check("wait err", {31'b0, MEM_err}, 32'd0);
    check("wait dout", MEM_DataOut, 32'h55AA55AA);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
